// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl
//   EX-stage initiator for the HI/LO multiply/divide unit. Turns decoded
//   MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO into the unit's
//   Start/Op/We/HiLo/D1/D2 handshake. It covers the one-cycle gap between
//   Start and the unit raising Busy, stalls dependent HI/LO instructions, and
//   returns MFHI/MFLO data.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   md_valid, md_class   EX holds a HI/LO-class instruction of this class
//                        (0 MULTU,1 MULT,2 DIVU,3 DIV,4 MFHI,5 MFLO,6 MTHI,7 MTLO)
//   rs_data, rt_data     operands
//   flush                kill the EX instruction this cycle
//   md_busy, md_hi/lo    status and results from the unit
//   md_start/op/we/hilo  control to the unit
//   md_d1, md_d2         data to the unit
//   stall                freeze IF/ID/EX
//   rd_data, rd_valid    MFHI/MFLO result
//   timeout_err          sticky watchdog flag, cleared only by rst
//
// state  | meaning
// IDLE   | unit free; HI/LO instructions are accepted here only
// LAUNCH | md_start high for exactly this cycle, operands held
// WAIT   | unit busy; count the cycles, watchdog on TIMEOUT_CYC
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYC = 63,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid,
  input  logic [2:0]  md_class,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        md_we,
  output logic        md_hilo,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        d1_q, d1_d;
  logic [31:0]        d2_q, d2_d;
  logic               timeout_q, timeout_d;

  logic is_idle;
  logic take;
  logic is_arith;
  logic is_mt;
  logic is_mf;

  // Stall only exists outside IDLE, so acceptance reduces to valid & ~flush in IDLE.
  assign is_idle  = (state_q == ST_IDLE);
  assign take     = md_valid & ~flush & is_idle;
  assign is_arith = ~md_class[2];
  assign is_mt    = md_class[2] & md_class[1];
  assign is_mf    = md_class[2] & ~md_class[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      op_q      <= 2'b00;
      d1_q      <= 32'h0;
      d2_q      <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (take && is_arith) begin
          op_d    = md_class[1:0];
          d1_d    = rs_data;
          d2_d    = rt_data;
          state_d = ST_LAUNCH;
        end
      end
      // The arith instruction has already retired, so flush cannot cancel here.
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!md_busy) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == CNT_W'(TIMEOUT_CYC)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          count_d   = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // md_start only exists in LAUNCH and md_we only in IDLE, so they never overlap.
  always_comb begin
    md_start    = (state_q == ST_LAUNCH);
    md_op       = op_q;
    md_d2       = d2_q;
    md_we       = take & is_mt;
    md_hilo     = ~md_class[0];
    md_d1       = (take & is_mt) ? rs_data : d1_q;
    stall       = md_valid & ~flush & ~is_idle;
    rd_valid    = take & is_mf;
    rd_data     = md_class[0] ? md_lo : md_hi;
    timeout_err = timeout_q;
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
module tb_muldiv_issue_ctrl;
  localparam int TIMEOUT_CYC = 63;
  localparam int MUL_LAT     = 11;
  localparam int DIV_LAT     = 41;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid;
  logic [2:0]  md_class;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_we;
  logic        md_hilo;
  logic [31:0] md_d1;
  logic [31:0] md_d2;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        timeout_err;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .md_valid(md_valid), .md_class(md_class),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .md_busy(md_busy),
    .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_op(md_op),
    .md_we(md_we), .md_hilo(md_hilo), .md_d1(md_d1), .md_d2(md_d2),
    .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid),
    .timeout_err(timeout_err)
  );

  // Arithmetic of the HI/LO unit; returns {hi, lo}. Division by zero keeps HI/LO.
  function automatic logic [63:0] unit_calc(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    logic [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    case (op)
      2'd0: return {32'h0, a} * {32'h0, b};
      2'd1: return sa * sb;
      2'd2: begin
        if (b == 32'h0) return {hi, lo};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {hi, lo};
        q = qa / qb;
        r = qa % qb;
        return {r, q};
      end
    endcase
  endfunction

  // Behavioural mul/div unit: Busy for the op latency after sampling Start.
  logic       u_stuck;
  int         u_cnt;
  logic [1:0] u_op;
  logic [31:0] u_a, u_b;

  always @(posedge clk) begin
    if (rst) begin
      md_busy <= 1'b0;
      u_cnt   <= 0;
      md_hi   <= 32'h0;
      md_lo   <= 32'h0;
    end else if (md_we) begin
      if (md_hilo) md_hi <= md_d1;
      else         md_lo <= md_d1;
    end else if (md_start && !md_busy) begin
      md_busy <= 1'b1;
      u_cnt   <= md_op[1] ? DIV_LAT : MUL_LAT;
      u_op    <= md_op;
      u_a     <= md_d1;
      u_b     <= md_d2;
    end else if (md_busy && !u_stuck) begin
      if (u_cnt == 1) begin
        md_busy        <= 1'b0;
        {md_hi, md_lo} <= unit_calc(u_op, u_a, u_b, md_hi, md_lo);
      end
      u_cnt <= u_cnt - 1;
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference: architectural HI/LO plus a count of cycles the controller stays busy.
  logic [31:0] ref_hi, ref_lo;
  int          busy_left;
  logic        start_now;
  logic [1:0]  exp_op;
  logic [31:0] exp_d1, exp_d2;
  logic        last_acc;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_hi    = 32'h0;
    ref_lo    = 32'h0;
    busy_left = 0;
    start_now = 1'b0;
  endtask

  task automatic step();
    logic idle, acc, mt, mf;
    @(negedge clk);
    idle = (busy_left == 0);
    acc  = md_valid && !flush && idle;
    mt   = acc && (md_class >= 3'd6);
    mf   = acc && (md_class == 3'd4 || md_class == 3'd5);
    check("stall", 32'(stall), 32'(md_valid && !flush && !idle));
    check("md_start", 32'(md_start), 32'(start_now));
    if (start_now) begin
      check("md_op", 32'(md_op), 32'(exp_op));
      check("md_d1_arith", md_d1, exp_d1);
      check("md_d2", md_d2, exp_d2);
    end
    check("md_we", 32'(md_we), 32'(mt));
    if (mt) begin
      check("md_hilo", 32'(md_hilo), 32'(md_class == 3'd6));
      check("md_d1_mt", md_d1, rs_data);
    end
    check("rd_valid", 32'(rd_valid), 32'(mf));
    if (mf) check("rd_data", rd_data, (md_class == 3'd4) ? ref_hi : ref_lo);
    check("timeout_err", 32'(timeout_err), 32'd0);
    last_acc = acc;
    last_rd  = rd_data;
    @(posedge clk);
    start_now = 1'b0;
    if (busy_left > 0) busy_left--;
    if (acc && md_class <= 3'd3) begin
      busy_left = (md_class[1] ? DIV_LAT : MUL_LAT) + 2;
      start_now = 1'b1;
      exp_op    = md_class[1:0];
      exp_d1    = rs_data;
      exp_d2    = rt_data;
      {ref_hi, ref_lo} = unit_calc(md_class[1:0], rs_data, rt_data, ref_hi, ref_lo);
    end else if (mt) begin
      if (md_class == 3'd6) ref_hi = rs_data;
      else                  ref_lo = rs_data;
    end
    #1;
  endtask

  // Present one instruction and hold it until accepted; report stall cycles and rd_data.
  task automatic issue(input logic [2:0] cls, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] rdat, output int stalls);
    md_valid = 1'b1;
    md_class = cls;
    rs_data  = rs;
    rt_data  = rt;
    flush    = 1'b0;
    stalls   = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_acc) break;
      stalls++;
    end
    if (!last_acc) check("issue_bound", 32'd0, 32'd1);
    rdat     = last_rd;
    md_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] rd;
    int          st;
    int          waited;
    rst = 1'b1; md_valid = 1'b0; md_class = 3'd0; rs_data = 32'h0; rt_data = 32'h0;
    flush = 1'b0; u_stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_md_start", 32'(md_start), 32'd0);
    check("rst_md_op", 32'(md_op), 32'd0);
    check("rst_md_d1", md_d1, 32'h0);
    check("rst_md_d2", md_d2, 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // MULTU then MFLO/MFHI
    issue(3'd0, 32'hFFFF_FFFF, 32'h2, rd, st);
    issue(3'd5, 32'h0, 32'h0, rd, st);
    check("t1_mflo_stalls", 32'(st), 32'(MUL_LAT + 2));
    check("t1_mflo", rd, 32'hFFFF_FFFE);
    issue(3'd4, 32'h0, 32'h0, rd, st);
    check("t1_mfhi", rd, 32'h0000_0001);

    // DIV -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'h2, rd, st);
    issue(3'd5, 32'h0, 32'h0, rd, st);
    check("t2_div_stalls", 32'(st), 32'(DIV_LAT + 2));
    check("t2_mflo", rd, 32'hFFFF_FFFD);
    issue(3'd4, 32'h0, 32'h0, rd, st);
    check("t2_mfhi", rd, 32'hFFFF_FFFF);

    // MTHI then MFHI back to back
    issue(3'd6, 32'h1234_5678, 32'h0, rd, st);
    check("t3_mthi_stalls", 32'(st), 32'd0);
    issue(3'd4, 32'h0, 32'h0, rd, st);
    check("t3_mfhi", rd, 32'h1234_5678);

    // MULT then MTLO during WAIT
    issue(3'd1, 32'hFFFF_FFFD, 32'h7, rd, st);
    issue(3'd7, 32'hCAFE_F00D, 32'h0, rd, st);
    check("t4_mtlo_stalls", 32'(st), 32'(MUL_LAT + 2));
    issue(3'd5, 32'h0, 32'h0, rd, st);
    check("t4_mflo", rd, 32'hCAFE_F00D);
    issue(3'd4, 32'h0, 32'h0, rd, st);
    check("t4_mfhi", rd, 32'hFFFF_FFFF);

    // Flushed arith in IDLE never starts the unit
    md_valid = 1'b1; md_class = 3'd2; rs_data = 32'd9; rt_data = 32'd3; flush = 1'b1;
    step();
    md_valid = 1'b0; flush = 1'b0;
    step();
    step();

    // Divide by zero leaves HI/LO unchanged
    issue(3'd6, 32'h0BAD_BEEF, 32'h0, rd, st);
    issue(3'd2, 32'd5, 32'd0, rd, st);
    issue(3'd4, 32'h0, 32'h0, rd, st);
    check("dbz_mfhi", rd, 32'h0BAD_BEEF);

    // Reset while in WAIT
    issue(3'd3, 32'd100, 32'd7, rd, st);
    repeat (5) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    issue(3'd4, 32'h0, 32'h0, rd, st);
    check("rst_wait_stalls", 32'(st), 32'd0);
    check("rst_wait_hi", rd, 32'h0);

    // Randomized traffic against the reference
    for (int n = 0; n < 1500; n++) begin
      md_valid = ($urandom_range(0, 9) < 7);
      md_class = 3'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 9) == 0);
      rs_data  = $urandom;
      rt_data  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      step();
    end
    md_valid = 1'b0; flush = 1'b0;
    repeat (50) step();

    // Busy stuck high: watchdog
    u_stuck = 1'b1;
    issue(3'd1, 32'd3, 32'd4, rd, st);
    md_valid = 1'b1; md_class = 3'd4;
    repeat (59) @(posedge clk);
    #1;
    @(negedge clk);
    check("wd_early_err", 32'(timeout_err), 32'd0);
    check("wd_still_stall", 32'(stall), 32'd1);
    waited = 0;
    while (!timeout_err && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("wd_err_set", 32'(timeout_err), 32'd1);
    check("wd_back_idle", 32'(stall), 32'd0);
    md_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("wd_sticky", 32'(timeout_err), 32'd1);
    u_stuck = 1'b0;
    do_reset();
    @(negedge clk);
    check("wd_cleared", 32'(timeout_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
